// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide unit controller with HI/LO registers.
// The full 64-bit product or quotient/remainder is computed on the Start edge
// and held in pending registers. Busy then stays high for a fixed number of
// cycles, and the pending result is committed to HI/LO on the edge that ends
// the last busy cycle.
//
// Ports:
//   Clk     - clock; all state changes on the rising edge
//   Reset   - asynchronous, active-low reset
//   Start   - launch the E-stage operation (only accepted while idle)
//   MDOp    - 00 mult, 01 multu, 10 div, 11 divu
//   A, B    - rs / rt operands; A is also the mthi/mtlo write data
//   WriteHI - mthi (only accepted while idle, and Start takes priority)
//   WriteLO - mtlo (only accepted while idle, and Start takes priority)
//   MDUseD  - the D-stage instruction uses the MDU
//   Busy    - an operation is in progress
//   StallMD - stall request: MDUseD & (Start | Busy)
//   HI, LO  - architectural HI/LO registers
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [1:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        WriteHI,
  input  logic        WriteLO,
  input  logic        MDUseD,
  output logic        Busy,
  output logic        StallMD,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, MULT, DIV} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic [31:0]        hi_pend_q, hi_pend_d, lo_pend_q, lo_pend_d;
  logic               pend_wr_q, pend_wr_d;

  logic [63:0]        prod_s, prod_u;
  logic               div_signed, b_zero, q_neg;
  logic [31:0]        dvd, dvs, q_mag, r_mag, quot, rem;

  // Signed division runs on magnitudes and re-applies the signs afterwards:
  // this truncates toward zero, gives the remainder the dividend's sign, and
  // makes 0x80000000 / -1 fall out as quotient 0x80000000, remainder 0.
  always_comb begin
    prod_s     = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    prod_u     = {32'd0, A} * {32'd0, B};
    div_signed = ~MDOp[0];
    b_zero     = (B == '0);
    q_neg      = div_signed & (A[31] ^ B[31]);
    dvd        = (div_signed & A[31]) ? (32'd0 - A) : A;
    dvs        = (div_signed & B[31]) ? (32'd0 - B) : B;
    if (b_zero) begin
      dvs = 32'd1;
    end
    q_mag      = dvd / dvs;
    r_mag      = dvd % dvs;
    quot       = q_neg ? (32'd0 - q_mag) : q_mag;
    rem        = (div_signed & A[31]) ? (32'd0 - r_mag) : r_mag;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    hi_pend_d = hi_pend_q;
    lo_pend_d = lo_pend_q;
    pend_wr_d = pend_wr_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          if (MDOp[1]) begin
            state_d   = DIV;
            cnt_d     = CNT_W'(DIV_CYCLES);
            hi_pend_d = rem;
            lo_pend_d = quot;
            // Divide by zero still occupies the unit but commits nothing.
            pend_wr_d = ~b_zero;
          end else begin
            state_d   = MULT;
            cnt_d     = CNT_W'(MULT_CYCLES);
            hi_pend_d = MDOp[0] ? prod_u[63:32] : prod_s[63:32];
            lo_pend_d = MDOp[0] ? prod_u[31:0]  : prod_s[31:0];
            pend_wr_d = 1'b1;
          end
        end else begin
          if (WriteHI) hi_d = A;
          if (WriteLO) lo_d = A;
        end
      end
      MULT, DIV: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (pend_wr_q) begin
            hi_d = hi_pend_q;
            lo_d = lo_pend_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      hi_pend_q <= '0;
      lo_pend_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      hi_pend_q <= hi_pend_d;
      lo_pend_q <= lo_pend_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign Busy    = (state_q != IDLE);
  assign StallMD = MDUseD & (Start | Busy);
  assign HI      = hi_q;
  assign LO      = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed self-checking bench for mdu_ctrl with default
// parameters (5 multiply cycles, 10 divide cycles).
module tb_mdu_ctrl;

  logic        Clk, Reset, Start, WriteHI, WriteLO, MDUseD;
  logic [1:0]  MDOp;
  logic [31:0] A, B;
  logic        Busy, StallMD;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
    .WriteHI(WriteHI), .WriteLO(WriteLO), .MDUseD(MDUseD),
    .Busy(Busy), .StallMD(StallMD), .HI(HI), .LO(LO)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    MDOp  = op;
    A     = a;
    B     = b;
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  // Expects Busy high for exactly n cycles with HI/LO held, then Busy low.
  task automatic busy_phase(input string tag, input int n,
                            input logic [31:0] hi_hold, input logic [31:0] lo_hold);
    for (int i = 0; i < n; i++) begin
      check({tag, "_busy"}, {31'd0, Busy}, 32'd1);
      check({tag, "_hi_hold"}, HI, hi_hold);
      check({tag, "_lo_hold"}, LO, lo_hold);
      tick();
    end
    check({tag, "_done"}, {31'd0, Busy}, 32'd0);
  endtask

  initial begin
    Reset = 1'b0; Start = 1'b0; WriteHI = 1'b0; WriteLO = 1'b0;
    MDUseD = 1'b0; MDOp = 2'b00; A = '0; B = '0;
    #2;
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_hi", HI, 32'h0);
    check("rst_lo", LO, 32'h0);
    check("rst_stall", {31'd0, StallMD}, 32'd0);
    tick(); tick();
    #2 Reset = 1'b1;
    tick();

    // mult 3 * -4, MDUseD high throughout: stall while starting and busy.
    MDUseD = 1'b1; MDOp = 2'b00; A = 32'd3; B = 32'hFFFF_FFFC; Start = 1'b1;
    #1;
    check("mult_stall_start", {31'd0, StallMD}, 32'd1);
    tick();
    Start = 1'b0;
    #1;
    check("mult_stall_busy", {31'd0, StallMD}, 32'd1);
    busy_phase("mult", 5, 32'h0, 32'h0);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFF4);
    MDUseD = 1'b0;
    #1;
    check("idle_nostall", {31'd0, StallMD}, 32'd0);

    // multu 0xFFFFFFFF * 2 with mthi/mtlo asserted too: Start wins.
    WriteHI = 1'b1; WriteLO = 1'b1;
    launch(2'b01, 32'hFFFF_FFFF, 32'd2);
    WriteHI = 1'b0; WriteLO = 1'b0;
    busy_phase("multu", 5, 32'hFFFF_FFFF, 32'hFFFF_FFF4);
    check("multu_hi", HI, 32'h0000_0001);
    check("multu_lo", LO, 32'hFFFF_FFFE);

    // mthi + mtlo together, then mthi alone.
    A = 32'h1234_5678; WriteHI = 1'b1; WriteLO = 1'b1;
    tick();
    check("mthilo_hi", HI, 32'h1234_5678);
    check("mthilo_lo", LO, 32'h1234_5678);
    A = 32'hAAAA_AAAA; WriteLO = 1'b0;
    tick();
    WriteHI = 1'b0;
    check("mthi_hi", HI, 32'hAAAA_AAAA);
    check("mthi_lo_keep", LO, 32'h1234_5678);

    // div -7 / 2; a second Start plus mthi/mtlo in busy cycle 3 are ignored.
    launch(2'b10, 32'hFFFF_FFF9, 32'd2);
    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin
        Start = 1'b1; MDOp = 2'b01; A = 32'd5; B = 32'd5;
        WriteHI = 1'b1; WriteLO = 1'b1; MDUseD = 1'b1;
      end else begin
        Start = 1'b0; WriteHI = 1'b0; WriteLO = 1'b0; MDUseD = 1'b0;
      end
      #1;
      check("div_busy", {31'd0, Busy}, 32'd1);
      check("div_stall", {31'd0, StallMD}, (i == 2) ? 32'd1 : 32'd0);
      check("div_hi_hold", HI, 32'hAAAA_AAAA);
      check("div_lo_hold", LO, 32'h1234_5678);
      tick();
    end
    Start = 1'b0; WriteHI = 1'b0; WriteLO = 1'b0; MDUseD = 1'b0;
    check("div_done", {31'd0, Busy}, 32'd0);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);
    tick();
    check("div_noreissue", {31'd0, Busy}, 32'd0);

    // divu by zero: full busy time, HI/LO untouched.
    launch(2'b11, 32'd1234, 32'd0);
    busy_phase("divu0", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    check("divu0_hi", HI, 32'hFFFF_FFFF);
    check("divu0_lo", LO, 32'hFFFF_FFFD);

    // div 7 / -2: quotient -3, remainder +1.
    launch(2'b10, 32'd7, 32'hFFFF_FFFE);
    busy_phase("divpn", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    check("divpn_lo", LO, 32'hFFFF_FFFD);
    check("divpn_hi", HI, 32'h0000_0001);

    // divu 100 / 7: quotient 14, remainder 2.
    launch(2'b11, 32'd100, 32'd7);
    busy_phase("divu", 10, 32'h0000_0001, 32'hFFFF_FFFD);
    check("divu_lo", LO, 32'd14);
    check("divu_hi", HI, 32'd2);

    // Overflow case 0x80000000 / -1.
    launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    busy_phase("divov", 10, 32'd2, 32'd14);
    check("divov_lo", LO, 32'h8000_0000);
    check("divov_hi", HI, 32'h0000_0000);

    // Reset in busy cycle 3 of a div: immediate clear, no late commit.
    launch(2'b10, 32'd100, 32'd7);
    tick(); tick();
    check("rstmid_busy_before", {31'd0, Busy}, 32'd1);
    #2 Reset = 1'b0;
    #1;
    check("rstmid_busy", {31'd0, Busy}, 32'd0);
    check("rstmid_hi", HI, 32'h0);
    check("rstmid_lo", LO, 32'h0);
    Start = 1'b1; WriteHI = 1'b1; A = 32'h5555_5555;
    tick();
    check("rsthold_busy", {31'd0, Busy}, 32'd0);
    check("rsthold_hi", HI, 32'h0);
    Start = 1'b0; WriteHI = 1'b0;
    #2 Reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("rstpost_busy", {31'd0, Busy}, 32'd0);
    end
    check("rstpost_hi", HI, 32'h0);
    check("rstpost_lo", LO, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
